// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrlState_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_CNT_W          = 32;
  localparam int REG_IDX_W              = 4;

endpackage

// File: rtl/pipeline_controller_if.sv
// Datapath <-> controller signal bundle; the datapath is master, the controller is slave.
interface pipeline_controller_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic [REG_IDX_W-1:0] src1_ID;
  logic [REG_IDX_W-1:0] src2_ID;
  logic                 useSrc1_ID;
  logic                 twoSrc_ID;
  logic [REG_IDX_W-1:0] destEXE;
  logic                 wbEnEXE;
  logic                 memReadEXE;
  logic [REG_IDX_W-1:0] destMEM;
  logic                 wbEnMEM;
  logic                 forwardEn;
  logic                 branchTaken_EXE;
  logic                 memReq;
  logic                 memReady;

  logic                 hazard;
  logic                 freeze;
  logic                 flush;
  logic                 memStall;
  logic                 memTimeout;
  logic [CNT_W-1:0]     stallCycles;
  logic [CNT_W-1:0]     flushCount;
  logic [CNT_W-1:0]     hazardCount;

  modport master (
    output src1_ID, src2_ID, useSrc1_ID, twoSrc_ID, destEXE, wbEnEXE, memReadEXE,
           destMEM, wbEnMEM, forwardEn, branchTaken_EXE, memReq, memReady,
    input  hazard, freeze, flush, memStall, memTimeout, stallCycles, flushCount, hazardCount
  );

  modport slave (
    input  src1_ID, src2_ID, useSrc1_ID, twoSrc_ID, destEXE, wbEnEXE, memReadEXE,
           destMEM, wbEnMEM, forwardEn, branchTaken_EXE, memReq, memReady,
    output hazard, freeze, flush, memStall, memTimeout, stallCycles, flushCount, hazardCount
  );

endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// RAW hazard detection between the ID sources and the EXE/MEM destinations.
// Purely combinational; with forwarding only a load in EXE can still cause a hazard.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 useSrc1,
  input  logic                 twoSrc,
  input  logic [REG_IDX_W-1:0] destExe,
  input  logic                 wbEnExe,
  input  logic                 memReadExe,
  input  logic [REG_IDX_W-1:0] destMem,
  input  logic                 wbEnMem,
  input  logic                 forwardEn,
  output logic                 rawHaz
);

  logic rawExe;
  logic rawMem;

  always_comb begin
    rawExe = wbEnExe & ((useSrc1 & (src1 == destExe)) | (twoSrc & (src2 == destExe)));
    rawMem = wbEnMem & ((useSrc1 & (src1 == destMem)) | (twoSrc & (src2 == destMem)));
    rawHaz = forwardEn ? (rawExe & memReadExe) : (rawExe | rawMem);
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush controller: zero-latency hazard/freeze/flush/memStall, SRAM wait FSM,
// sticky wait timeout and wrapping performance counters. memStall outranks flush outranks hazard.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
)(
  input  logic                  clk,
  input  logic                  rst,
  pipeline_controller_if.slave  ctrl
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  ctrlState_t        state;
  logic [WAIT_W-1:0] waitCnt;
  logic              memTimeoutQ;
  logic [CNT_W-1:0]  stallCnt;
  logic [CNT_W-1:0]  flushCnt;
  logic [CNT_W-1:0]  hazardCnt;

  logic rawHaz;
  logic memStall;
  logic flush;
  logic hazard;
  logic freeze;

  hazard_detect u_hazardDetect (
    .src1       (ctrl.src1_ID),
    .src2       (ctrl.src2_ID),
    .useSrc1    (ctrl.useSrc1_ID),
    .twoSrc     (ctrl.twoSrc_ID),
    .destExe    (ctrl.destEXE),
    .wbEnExe    (ctrl.wbEnEXE),
    .memReadExe (ctrl.memReadEXE),
    .destMem    (ctrl.destMEM),
    .wbEnMem    (ctrl.wbEnMEM),
    .forwardEn  (ctrl.forwardEn),
    .rawHaz     (rawHaz)
  );

  // A wrong-path instruction in ID must never stall, hence hazard is masked by flush.
  always_comb begin
    memStall = ~rst & ctrl.memReq & ~ctrl.memReady;
    flush    = ~rst & ctrl.branchTaken_EXE & ~memStall;
    hazard   = ~rst & rawHaz & ~flush & ~memStall;
    freeze   = memStall | hazard;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= '0;
      memTimeoutQ <= 1'b0;
      stallCnt    <= '0;
      flushCnt    <= '0;
      hazardCnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            state   <= MEM_WAIT;
            waitCnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (ctrl.memReady || !ctrl.memReq) begin
            state <= RUN;
          end
          // Saturate so a long wait cannot wrap back below the limit.
          if (waitCnt != WAIT_LIMIT) begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end else begin
            memTimeoutQ <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase

      if (freeze) stallCnt  <= stallCnt + CNT_W'(1);
      if (flush)  flushCnt  <= flushCnt + CNT_W'(1);
      if (hazard) hazardCnt <= hazardCnt + CNT_W'(1);
    end
  end

  assign ctrl.hazard      = hazard;
  assign ctrl.freeze      = freeze;
  assign ctrl.flush       = flush;
  assign ctrl.memStall    = memStall;
  assign ctrl.memTimeout  = memTimeoutQ;
  assign ctrl.stallCycles = stallCnt;
  assign ctrl.flushCount  = flushCnt;
  assign ctrl.hazardCount = hazardCnt;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios plus randomized traffic against a reference model.
module tb_pipeline_controller;
  import pipeline_ctrl_pkg::*;

  localparam int T  = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_controller_if #(.CNT_W(CW)) bus ();

  pipeline_controller #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  logic [CW-1:0] mStall, mFlush, mHaz;
  bit            mWaiting;
  int            mWaitEdges;
  bit            mTimeout;
  bit            eHaz, eFrz, eFl, eMs;

  // Expected combinational outputs: list the registers ID actually reads and
  // ask whether a pending writer that cannot forward produces any of them.
  function automatic void modelComb();
    int  reads[$];
    bit  stuck;
    reads = {};
    if (bus.useSrc1_ID) reads.push_back(int'(bus.src1_ID));
    if (bus.twoSrc_ID)  reads.push_back(int'(bus.src2_ID));
    stuck = 1'b0;
    foreach (reads[i]) begin
      if (bus.wbEnEXE && reads[i] == int'(bus.destEXE) && (!bus.forwardEn || bus.memReadEXE)) stuck = 1'b1;
      if (bus.wbEnMEM && reads[i] == int'(bus.destMEM) && !bus.forwardEn) stuck = 1'b1;
    end
    eMs  = !rst && bus.memReq && !bus.memReady;
    eFl  = !rst && !eMs && bus.branchTaken_EXE;
    eHaz = !rst && !eMs && !eFl && stuck;
    eFrz = eMs || eHaz;
  endfunction

  // A wait lasts while the access is outstanding; timeout after more than T cycles inside it.
  function automatic void modelEdge();
    modelComb();
    if (rst) begin
      mStall = '0; mFlush = '0; mHaz = '0;
      mWaiting = 1'b0; mWaitEdges = 0; mTimeout = 1'b0;
    end else begin
      mStall += CW'(eFrz);
      mFlush += CW'(eFl);
      mHaz   += CW'(eHaz);
      if (mWaiting) begin
        mWaitEdges++;
        if (mWaitEdges > T) mTimeout = 1'b1;
        mWaiting = bus.memReq && !bus.memReady;
      end else if (bus.memReq && !bus.memReady) begin
        mWaiting   = 1'b1;
        mWaitEdges = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.src1_ID = 4'd0; bus.src2_ID = 4'd0; bus.useSrc1_ID = 1'b0; bus.twoSrc_ID = 1'b0;
    bus.destEXE = 4'd0; bus.wbEnEXE = 1'b0; bus.memReadEXE = 1'b0;
    bus.destMEM = 4'd0; bus.wbEnMEM = 1'b0; bus.forwardEn = 1'b1;
    bus.branchTaken_EXE = 1'b0; bus.memReq = 1'b0; bus.memReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.memReq = 1'b1; bus.branchTaken_EXE = 1'b1;
    bus.forwardEn = 1'b0; bus.wbEnEXE = 1'b1; bus.destEXE = 4'd2;
    bus.src1_ID = 4'd2; bus.useSrc1_ID = 1'b1;
    tick(); tick();
    #1;
    nChecks++; if (bus.memStall !== 1'b0) begin nFails++; $display("FAIL reset_memStall got %b want 0", bus.memStall); end
    nChecks++; if (bus.flush !== 1'b0) begin nFails++; $display("FAIL reset_flush got %b want 0", bus.flush); end
    nChecks++; if (bus.hazard !== 1'b0) begin nFails++; $display("FAIL reset_hazard got %b want 0", bus.hazard); end
    nChecks++; if (bus.freeze !== 1'b0) begin nFails++; $display("FAIL reset_freeze got %b want 0", bus.freeze); end
    nChecks++; if (bus.memTimeout !== 1'b0) begin nFails++; $display("FAIL reset_timeout got %b want 0", bus.memTimeout); end
    nChecks++; if (bus.stallCycles !== '0 || bus.flushCount !== '0 || bus.hazardCount !== '0) begin
      nFails++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", bus.stallCycles, bus.flushCount, bus.hazardCount);
    end
    idle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    logic [CW-1:0] h0;
    h0 = bus.hazardCount;
    idle();
    bus.forwardEn = 1'b1; bus.memReadEXE = 1'b1; bus.wbEnEXE = 1'b1; bus.destEXE = 4'd3;
    bus.src1_ID = 4'd3; bus.useSrc1_ID = 1'b1;
    #1;
    nChecks++; if (bus.hazard !== 1'b1 || bus.freeze !== 1'b1) begin
      nFails++; $display("FAIL loaduse_first hazard/freeze got %b/%b want 1/1", bus.hazard, bus.freeze);
    end
    tick();
    // Load advanced to MEM, bubble in EXE.
    bus.wbEnEXE = 1'b0; bus.memReadEXE = 1'b0; bus.destEXE = 4'd0;
    bus.wbEnMEM = 1'b1; bus.destMEM = 4'd3;
    #1;
    nChecks++; if (bus.hazard !== 1'b0 || bus.freeze !== 1'b0) begin
      nFails++; $display("FAIL loaduse_second hazard/freeze got %b/%b want 0/0", bus.hazard, bus.freeze);
    end
    nChecks++; if (bus.hazardCount !== h0 + 1) begin
      nFails++; $display("FAIL loaduse_count got %0d want %0d", bus.hazardCount, h0 + 1);
    end
    tick();
    idle();
    #1;
  endtask

  task automatic test_no_forward();
    int hi;
    hi = 0;
    idle();
    bus.forwardEn = 1'b0;
    bus.src2_ID = 4'd5; bus.twoSrc_ID = 1'b1; bus.src1_ID = 4'd1; bus.useSrc1_ID = 1'b1;
    bus.wbEnEXE = 1'b1; bus.destEXE = 4'd5;
    #1; if (bus.hazard === 1'b1) hi++;
    tick();
    bus.wbEnEXE = 1'b0; bus.destEXE = 4'd0; bus.wbEnMEM = 1'b1; bus.destMEM = 4'd5;
    #1; if (bus.hazard === 1'b1) hi++;
    tick();
    bus.wbEnMEM = 1'b0; bus.destMEM = 4'd0;
    #1; if (bus.hazard === 1'b1) hi++;
    nChecks++; if (hi != 2) begin nFails++; $display("FAIL nofwd_cycles got %0d want 2", hi); end
    tick();
    idle();
    #1;
  endtask

  task automatic test_sram_wait();
    logic [CW-1:0] s0;
    int stalled;
    s0 = bus.stallCycles;
    stalled = 0;
    idle();
    bus.memReq = 1'b1; bus.memReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; if (bus.memStall === 1'b1 && bus.freeze === 1'b1) stalled++;
      tick();
    end
    nChecks++; if (stalled != 4) begin nFails++; $display("FAIL sram_stall_cycles got %0d want 4", stalled); end
    nChecks++; if (bus.stallCycles !== s0 + 4) begin
      nFails++; $display("FAIL sram_stallCycles got %0d want %0d", bus.stallCycles, s0 + 4);
    end
    bus.memReady = 1'b1;
    #1;
    nChecks++; if (bus.memStall !== 1'b0 || bus.freeze !== 1'b0) begin
      nFails++; $display("FAIL sram_ready memStall/freeze got %b/%b want 0/0", bus.memStall, bus.freeze);
    end
    tick();
    idle();
    #1;
  endtask

  task automatic test_branch_stall();
    logic [CW-1:0] f0;
    int badFlush;
    f0 = bus.flushCount;
    badFlush = 0;
    idle();
    bus.forwardEn = 1'b0; bus.wbEnEXE = 1'b1; bus.destEXE = 4'd7;
    bus.src1_ID = 4'd7; bus.useSrc1_ID = 1'b1;
    bus.branchTaken_EXE = 1'b1; bus.memReq = 1'b1; bus.memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (bus.flush !== 1'b0 || bus.hazard !== 1'b0) badFlush++;
      tick();
    end
    nChecks++; if (badFlush != 0) begin nFails++; $display("FAIL branch_during_stall bad cycles %0d want 0", badFlush); end
    bus.memReady = 1'b1;
    #1;
    nChecks++; if (bus.flush !== 1'b1) begin nFails++; $display("FAIL branch_release_flush got %b want 1", bus.flush); end
    nChecks++; if (bus.hazard !== 1'b0) begin nFails++; $display("FAIL branch_release_hazard got %b want 0", bus.hazard); end
    tick();
    nChecks++; if (bus.flushCount !== f0 + 1) begin
      nFails++; $display("FAIL branch_flushCount got %0d want %0d", bus.flushCount, f0 + 1);
    end
    idle();
    tick();
  endtask

  task automatic test_timeout();
    idle();
    bus.memReq = 1'b1; bus.memReady = 1'b0;
    tick();
    for (int k = 1; k <= T; k++) tick();
    nChecks++; if (bus.memTimeout !== 1'b0) begin nFails++; $display("FAIL timeout_early got %b want 0", bus.memTimeout); end
    tick();
    nChecks++; if (bus.memTimeout !== 1'b1) begin nFails++; $display("FAIL timeout_rise got %b want 1", bus.memTimeout); end
    bus.memReq = 1'b0;
    tick(); tick();
    nChecks++; if (bus.memTimeout !== 1'b1) begin nFails++; $display("FAIL timeout_sticky got %b want 1", bus.memTimeout); end
    // Reset while waiting again.
    bus.memReq = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    nChecks++; if (bus.memTimeout !== 1'b0) begin nFails++; $display("FAIL timeout_clear got %b want 0", bus.memTimeout); end
    nChecks++; if (bus.stallCycles !== '0 || bus.flushCount !== '0 || bus.hazardCount !== '0) begin
      nFails++; $display("FAIL timeout_rst_counters got %0d/%0d/%0d want 0", bus.stallCycles, bus.flushCount, bus.hazardCount);
    end
    // Fresh wait after reset must again need the full window.
    tick();
    for (int k = 1; k <= T; k++) tick();
    nChecks++; if (bus.memTimeout !== 1'b0) begin nFails++; $display("FAIL timeout_rearm_early got %b want 0", bus.memTimeout); end
    tick();
    nChecks++; if (bus.memTimeout !== 1'b1) begin nFails++; $display("FAIL timeout_rearm got %b want 1", bus.memTimeout); end
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.src1_ID = 4'($urandom_range(0, 3));
      bus.src2_ID = 4'($urandom_range(0, 3));
      bus.destEXE = 4'($urandom_range(0, 3));
      bus.destMEM = 4'($urandom_range(0, 3));
      bus.useSrc1_ID = 1'($urandom);
      bus.twoSrc_ID  = 1'($urandom);
      bus.wbEnEXE    = 1'($urandom);
      bus.memReadEXE = 1'($urandom);
      bus.wbEnMEM    = 1'($urandom);
      bus.forwardEn  = 1'($urandom);
      bus.branchTaken_EXE = ($urandom_range(0, 3) == 0);
      bus.memReq   = ($urandom_range(0, 2) != 0);
      bus.memReady = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 299) == 0);
      #1;
      modelComb();
      nChecks++; if ({bus.memStall, bus.flush, bus.hazard, bus.freeze} !== {eMs, eFl, eHaz, eFrz}) begin
        nFails++; $display("FAIL rand_comb cycle %0d got ms/fl/hz/fz %b%b%b%b want %b%b%b%b", i,
                           bus.memStall, bus.flush, bus.hazard, bus.freeze, eMs, eFl, eHaz, eFrz);
      end
      tick();
      nChecks++; if (bus.stallCycles !== mStall || bus.flushCount !== mFlush || bus.hazardCount !== mHaz) begin
        nFails++; $display("FAIL rand_counters cycle %0d got %0d/%0d/%0d want %0d/%0d/%0d", i,
                           bus.stallCycles, bus.flushCount, bus.hazardCount, mStall, mFlush, mHaz);
      end
      nChecks++; if (bus.memTimeout !== mTimeout) begin
        nFails++; $display("FAIL rand_timeout cycle %0d got %b want %b", i, bus.memTimeout, mTimeout);
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_forward();
    test_sram_wait();
    test_branch_stall();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush controller for the five-stage ARM pipeline. It drives the `freeze`, `flush` and `hazard` nets that are currently tied low at top level. It detects RAW hazards between the ID-stage sources and the EXE/MEM destinations, and sequences multi-cycle SRAM accesses through a wait state machine. It also keeps stall and flush performance counters. It sits beside the datapath in the top module and feeds the IF stage, ID stage and all pipeline registers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: consecutive MEM_WAIT cycles before `memTimeout` is raised.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `src1_ID`, `src2_ID`  in  4 each  source registers (Rn, Rm) of the instruction in ID.
- `useSrc1_ID`  in  1  instruction in ID reads Rn.
- `twoSrc_ID`  in  1  instruction in ID reads Rm (register operand or store).
- `destEXE`  in  4  destination register of the instruction in EXE.
- `wbEnEXE`  in  1  write-back enable of the instruction in EXE.
- `memReadEXE`  in  1  the instruction in EXE is a load.
- `destMEM`  in  4  destination register of the instruction in MEM.
- `wbEnMEM`  in  1  write-back enable of the instruction in MEM.
- `forwardEn`  in  1  forwarding unit active.
- `branchTaken_EXE`  in  1  branch resolved taken in EXE.
- `memReq`  in  1  the MEM stage holds a load or store.
- `memReady`  in  1  SRAM access completes this cycle.
- `hazard`  out  1  ID inserts a bubble into ID/EXE.
- `freeze`  out  1  hold PC and the IF/ID register.
- `flush`  out  1  clear the IF/ID and ID/EXE registers.
- `memStall`  out  1  hold ID/EXE, EXE/MEM and MEM/WB.
- `memTimeout`  out  1  sticky error flag.
- `stallCycles`, `flushCount`, `hazardCount`  out  `CNT_W` each  performance counters.

## Operation
- rawEXE = wbEnEXE & ((useSrc1_ID & src1_ID==destEXE) | (twoSrc_ID & src2_ID==destEXE)).
- rawMEM is the same expression evaluated against destMEM and wbEnMEM.
- rawHaz = forwardEn ? (rawEXE & memReadEXE) : (rawEXE | rawMEM).
- memStall = memReq & ~memReady. This holds in both states; it does not wait for registered state.
- Priority: memStall > flush > hazard.
  - flush = branchTaken_EXE & ~memStall.
  - hazard = rawHaz & ~flush & ~memStall, because the wrong-path instruction in ID must not stall.
  - freeze = memStall | hazard.
- FSM states are RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when memReq & ~memReady.
  - MEM_WAIT -> RUN when memReady, or when memReq drops (defensive).
  - A zero-wait access, where memReq and memReady are both high in RUN, stays in RUN.
- The wait counter clears on entry to MEM_WAIT and increments each cycle spent in MEM_WAIT.
- When the wait counter reaches TIMEOUT_CYCLES, memTimeout sets on the next edge and holds until rst. The stall is not aborted.
- Counters wrap modulo 2^CNT_W:
  - stallCycles increments on every cycle with freeze=1.
  - flushCount increments on every cycle with flush=1.
  - hazardCount increments on every cycle with hazard=1.

## Timing
- hazard, freeze, flush and memStall are combinational from the current inputs, with zero latency. While rst=1 they are forced to 0.
- At the edge where rst=1, the next state is:
  - state = RUN
  - wait counter = 0
  - memTimeout = 0
  - all counters = 0
- A load-use hazard with forwarding produces exactly one bubble. The next cycle the load is in MEM, so rawHaz deasserts.
- Without forwarding, a dependency stalls 2 cycles (EXE, then MEM). Write-back is assumed to write in the first half-cycle.
- A branch taken while memStall=1 keeps flush at 0. branchTaken_EXE stays high because EXE is frozen, so flush asserts in the cycle memReady arrives.
- rst asserted in MEM_WAIT returns to RUN at that edge. Counters and memTimeout clear at the same edge.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - state enum {RUN, MEM_WAIT}
  - default TIMEOUT_CYCLES and CNT_W
  - register-index width constant (4)
- Sub-module `hazard_detect`: purely combinational rawEXE/rawMEM/rawHaz logic, reusable by the forwarding unit.
- Top-level `pipeline_controller` holds:
  - the FSM
  - the wait counter, of width $clog2(TIMEOUT_CYCLES+1)
  - the sticky flag
  - the counters
  - the priority logic

## Test plan
- Load-use hazard: forwardEn=1, memReadEXE=1, wbEnEXE=1, destEXE=3, src1_ID=3, useSrc1_ID=1 -> hazard=1 and freeze=1 for exactly 1 cycle; hazardCount=1.
- No-forward RAW: forwardEn=0, an ADD writes R5 and the next instruction reads R5 -> hazard high 2 cycles (EXE match, then MEM match).
- SRAM wait: memReq=1, memReady held low 4 cycles -> memStall=freeze=1 for 4 cycles, state MEM_WAIT, stallCycles=4; memReady=1 -> RUN, memStall=0.
- Branch during stall: branchTaken_EXE=1 with memStall=1 for 3 cycles -> flush=0 throughout, flush=1 in the memReady cycle, flushCount=1; a simultaneous rawHaz gives hazard=0.
- Timeout: TIMEOUT_CYCLES=8, memReady never asserted -> memTimeout rises after 8 MEM_WAIT cycles and stays high; rst=1 for one edge -> memTimeout=0, state RUN, counters=0.
